// File: rtl/sti_rx_if.sv
// sti_rx_if -- bus bundle for the serial-to-byte receiver.
//   si_data/si_valid      : serial bit stream from the upstream transmitter
//   cfg_length/cfg_msb    : frame length (8*(n+1) bits) and bit order
//   out_data/out_addr     : assembled byte and its running byte address
//   out_valid/out_ready   : byte handshake toward the consumer
//   frame_done/frame_err/overrun : one-cycle status pulses
// master = the environment (transmitter + consumer), slave = sti_rx.
interface sti_rx_if;
   logic       si_data;
   logic       si_valid;
   logic [1:0] cfg_length;
   logic       cfg_msb;
   logic [7:0] out_data;
   logic [7:0] out_addr;
   logic       out_valid;
   logic       out_ready;
   logic       frame_done;
   logic       frame_err;
   logic       overrun;

   modport master (
      output si_data, si_valid, cfg_length, cfg_msb, out_ready,
      input  out_data, out_addr, out_valid, frame_done, frame_err, overrun
   );

   modport slave (
      input  si_data, si_valid, cfg_length, cfg_msb, out_ready,
      output out_data, out_addr, out_valid, frame_done, frame_err, overrun
   );
endinterface

// File: rtl/sti_rx.sv
// sti_rx -- serial frame receiver. Collects one contiguous si_valid run,
// checks its length against the configured 8/16/24/32 bits, then drains
// the assembled bytes one per handshake with an auto-incrementing address.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active high
//   bus   : sti_rx_if.slave (serial input, config, byte output, status)
module sti_rx (
   input  logic     clk,
   input  logic     reset,
   sti_rx_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RECV, CHECK, DRAIN} state_e;

   state_e          state_q, state_d;
   logic [5:0]      count_q, count_d;      // bits seen, saturates at 33
   logic [1:0]      len_q, len_d;
   logic            msb_q, msb_d;
   logic [3:0][7:0] stage_q, stage_d;
   logic [1:0]      idx_q, idx_d;
   logic [7:0]      addr_q, addr_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            ovr_q, ovr_d;

   logic [5:0]      exp_cnt;
   logic            len_ok;
   logic            accept;
   logic            last;
   logic [4:0]      pos;
   logic            msb_use;
   logic [2:0]      bsel;

   // Expected bit count 8*(len+1), from the length latched at frame start.
   assign exp_cnt = {({1'b0, len_q} + 3'd1), 3'b000};
   assign len_ok  = (count_q == exp_cnt);
   assign accept  = (state_q == DRAIN) && bus.out_ready;
   assign last    = (idx_q == len_q);

   // Bit position of the incoming bit; the first bit arrives in IDLE before
   // the config is latched, so use the live cfg_msb for it.
   assign pos     = (state_q == IDLE) ? 5'd0 : count_q[4:0];
   assign msb_use = (state_q == IDLE) ? bus.cfg_msb : msb_q;
   assign bsel    = msb_use ? ~pos[2:0] : pos[2:0];

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (bus.si_valid)    state_d = RECV;
         RECV:  if (!bus.si_valid)   state_d = CHECK;
         CHECK: state_d = len_ok ? DRAIN : IDLE;
         DRAIN: if (accept && last)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      bus.out_valid  = (state_q == DRAIN);
      bus.out_data   = stage_q[idx_q];
      bus.out_addr   = addr_q;
      bus.frame_done = done_q;
      bus.frame_err  = err_q;
      bus.overrun    = ovr_q;
   end

   // ---------------- datapath next-state ----------------
   always_comb begin
      count_d = count_q;
      len_d   = len_q;
      msb_d   = msb_q;
      stage_d = stage_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ovr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.si_valid) begin
               stage_d              = '0;
               stage_d[0][bsel]     = bus.si_data;
               len_d                = bus.cfg_length;
               msb_d                = bus.cfg_msb;
               count_d              = 6'd1;
            end
         end
         RECV: begin
            if (bus.si_valid) begin
               // Bits past the 32nd are counted (to flag the mismatch) but not stored.
               if (!count_q[5])        stage_d[pos[4:3]][bsel] = bus.si_data;
               if (count_q != 6'd33)   count_d = count_q + 6'd1;
            end
         end
         CHECK: begin
            idx_d = 2'd0;
            ovr_d = bus.si_valid;
            if (!len_ok) begin
               err_d   = 1'b1;
               stage_d = '0;
            end
         end
         DRAIN: begin
            ovr_d = bus.si_valid;
            if (accept) begin
               addr_d = addr_q + 8'd1;
               if (last) begin
                  done_d = 1'b1;
                  idx_d  = 2'd0;
               end else begin
                  idx_d  = idx_q + 2'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         len_q   <= '0;
         msb_q   <= 1'b0;
         stage_q <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         len_q   <= len_d;
         msb_q   <= msb_d;
         stage_q <= stage_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: tb/tb_sti_rx.sv
// tb_sti_rx -- directed self-checking bench for sti_rx.
module tb_sti_rx;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   sti_rx_if bus ();

   sti_rx dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(bus.out_valid),  0);
      chk({tag, "_done"},  32'(bus.frame_done), 0);
      chk({tag, "_err"},   32'(bus.frame_err),  0);
      chk({tag, "_ovr"},   32'(bus.overrun),    0);
      chk({tag, "_data"},  32'(bus.out_data),   0);
      chk({tag, "_addr"},  32'(bus.out_addr),   0);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      tick();
      chk_all_zero(tag);
      reset = 1'b0;
   endtask

   // Send n bits, bits[i] is the i-th bit on the wire. Config is only
   // correct on the first bit (the DUT must latch it), then si_valid drops.
   // On return the DUT has just entered CHECK.
   task automatic send_bits(input logic [1:0] len, input logic msb,
                            input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         bus.si_valid   = 1'b1;
         bus.si_data    = bits[i];
         bus.cfg_length = (i == 0) ? len : ~len;
         bus.cfg_msb    = (i == 0) ? msb : ~msb;
         tick();
      end
      bus.si_valid = 1'b0;
      bus.si_data  = 1'b0;
      tick();
   endtask

   // Wait (bounded) for out_valid, then accept nb bytes back to back.
   task automatic drain(input string tag, input int lat, input int nb,
                        input logic [31:0] bytes, input logic [7:0] addr0);
      int w = 0;
      while (bus.out_valid !== 1'b1 && w < 8) begin
         tick();
         w++;
      end
      chk({tag, "_lat"}, 32'(w), 32'(lat));
      bus.out_ready = 1'b1;
      for (int b = 0; b < nb; b++) begin
         logic [7:0] a;
         a = addr0 + 8'(b);
         chk({tag, "_valid"}, 32'(bus.out_valid), 1);
         chk({tag, "_data"},  32'(bus.out_data),  32'(bytes[8*b +: 8]));
         chk({tag, "_addr"},  32'(bus.out_addr),  32'(a));
         tick();
      end
      chk({tag, "_done"},    32'(bus.frame_done), 1);
      chk({tag, "_endvld"},  32'(bus.out_valid),  0);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.si_data    = 1'b0;
      bus.si_valid   = 1'b0;
      bus.cfg_length = 2'd0;
      bus.cfg_msb    = 1'b0;
      bus.out_ready  = 1'b0;

      // Reset state
      do_reset("rst");

      // 8-bit, MSB-first: 1,0,1,1,0,0,1,0 -> 0xB2 at addr 0
      send_bits(2'd0, 1'b1, 32'h0000_004D, 8);
      chk("t1_check_novalid", 32'(bus.out_valid), 0);
      drain("t1", 1, 1, 32'h0000_00B2, 8'h00);
      tick();
      chk("t1_done_pulse_end", 32'(bus.frame_done), 0);

      // 16-bit, LSB-first 0x1234 -> 0x34 @0, 0x12 @1
      do_reset("rst2");
      send_bits(2'd1, 1'b0, 32'h0000_1234, 16);
      drain("t2", 1, 2, 32'h0000_1234, 8'h00);

      // len=3 but only 24 bits -> frame_err, no output, addr stays 2
      send_bits(2'd3, 1'b0, 32'h00AB_CDEF, 24);
      chk("t3_check_novalid", 32'(bus.out_valid), 0);
      tick();
      chk("t3_err",     32'(bus.frame_err), 1);
      chk("t3_novalid", 32'(bus.out_valid), 0);
      chk("t3_addr",    32'(bus.out_addr),  32'h02);
      tick();
      chk("t3_err_end", 32'(bus.frame_err), 0);
      chk("t3_novalid2", 32'(bus.out_valid), 0);
      // following good 8-bit frame
      send_bits(2'd0, 1'b0, 32'h0000_00A5, 8);
      drain("t3b", 1, 1, 32'h0000_00A5, 8'h02);

      // 24-bit MSB-first bytes 0x12,0x34,0x56 with a 5-cycle stall;
      // a one-cycle si_valid during DRAIN must only raise overrun.
      send_bits(2'd2, 1'b1, 32'h006A_2C48, 24);
      tick();
      for (int s = 0; s < 5; s++) begin
         chk("t4_stall_valid", 32'(bus.out_valid), 1);
         chk("t4_stall_data",  32'(bus.out_data),  32'h12);
         chk("t4_stall_addr",  32'(bus.out_addr),  32'h03);
         if (s == 2) chk("t4_overrun",    32'(bus.overrun), 1);
         if (s == 3) chk("t4_overrun_end", 32'(bus.overrun), 0);
         bus.si_valid = (s == 1);
         bus.si_data  = 1'b1;
         tick();
      end
      bus.si_valid = 1'b0;
      drain("t4", 0, 3, 32'h0056_3412, 8'h03);
      for (int s = 0; s < 3; s++) begin
         tick();
         chk("t4_nostart_valid", 32'(bus.out_valid), 0);
         chk("t4_nostart_err",   32'(bus.frame_err), 0);
      end

      // 257 back-to-back 8-bit frames: address wraps to 0 on frame 257
      do_reset("rst3");
      for (int k = 0; k < 257; k++) begin
         logic [7:0] kb;
         kb = 8'(k);
         send_bits(2'd0, 1'b0, 32'(kb), 8);
         drain("t5", 1, 1, 32'(kb), kb);
      end
      chk("t5_addr_after_wrap", 32'(bus.out_addr), 32'h01);

      // reset during RECV after 12 bits, with si_valid still high
      send_bits(2'd1, 1'b0, 32'h0000_0000, 0);
      for (int i = 0; i < 12; i++) begin
         bus.si_valid   = 1'b1;
         bus.si_data    = 1'(i % 2);
         bus.cfg_length = 2'd1;
         tick();
      end
      reset = 1'b1;
      tick();
      chk_all_zero("t6_rst");
      reset = 1'b0;
      bus.si_valid = 1'b0;
      tick();
      chk("t6_idle_novalid", 32'(bus.out_valid), 0);
      send_bits(2'd0, 1'b0, 32'h0000_003C, 8);
      drain("t6", 1, 1, 32'h0000_003C, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sti_rx.md
STI_RX -- requirements
Module: sti_rx

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port si_data, input, 1, serial bit from the upstream serial transmitter.
REQ-004 SHALL have port si_valid, input, 1, si_data qualifier; a frame is one contiguous run of si_valid=1.
REQ-005 SHALL have port cfg_length, input, 2, expected frame length: 0=8, 1=16, 2=24, 3=32 bits.
REQ-006 SHALL have port cfg_msb, input, 1, 1 = first-received bit of each byte is bit 7; 0 = bit 0.
REQ-007 SHALL have port out_data, output, 8, assembled byte.
REQ-008 SHALL have port out_addr, output, 8, byte address of out_data.
REQ-009 SHALL have port out_valid, output, 1, out_data/out_addr valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the byte when out_valid and out_ready are both 1 on a clock edge.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse when the last byte of a good frame is accepted.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on a length mismatch.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when bits arrive while the block cannot take them.

Function
REQ-014 SHALL implement states IDLE, RECV, CHECK and DRAIN.
REQ-015 SHALL, in IDLE with si_valid=1, capture si_data as bit 0 of the frame, latch cfg_length and cfg_msb, set count=1 and go to RECV; the latched config holds for the whole frame.
REQ-016 SHALL, in RECV with si_valid=1, capture one bit per cycle and increment count, saturating at 33.
REQ-017 SHALL, in RECV, store bits only while count<32 and ignore bits beyond 32.
REQ-018 SHALL, in RECV with si_valid=0, go to CHECK; no bit is captured in that cycle.
REQ-019 SHALL, in CHECK (exactly one cycle), go to DRAIN when count equals 8*(len+1) using the latched length.
REQ-020 SHALL, in CHECK on a count mismatch, pulse frame_err in the following cycle, discard the staging bytes, emit no output and go to IDLE.
REQ-021 SHALL assemble byte k from reception bits 8k..8k+7 in a 4-byte staging register; with msb=1 bit 8k maps to byte bit 7, with msb=0 bit 8k maps to byte bit 0.
REQ-022 SHALL, in DRAIN, hold out_valid=1 and drive out_data with staging byte idx, starting at idx=0.
REQ-023 SHALL, on each DRAIN handshake, increment idx and out_addr; out_addr wraps from 255 to 0 and persists across frames.
REQ-024 SHALL hold out_data and out_addr stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, when the byte with idx=len is accepted, deassert out_valid on the next cycle, pulse frame_done for exactly that one cycle and return to IDLE.
REQ-026 SHALL give a first-byte latency of 2 cycles (CHECK, then out_valid) after the edge where si_valid is first seen low.
REQ-027 SHALL discard si_valid=1 seen in CHECK or DRAIN and pulse overrun in the following cycle; this repeats each such cycle.
REQ-028 SHALL treat a frame as starting only in IDLE; a run of si_valid that began during DRAIN does not start a frame until si_valid is seen in IDLE.
REQ-029 SHALL support back-to-back frames, including a new frame in the first cycle of IDLE after DRAIN.

Reset
REQ-030 SHALL, when reset=1 at a clock edge, force state=IDLE and out_valid=0, frame_done=0, frame_err=0, overrun=0, out_data=0x00, out_addr=0x00, count=0, idx=0, staging=0.
REQ-031 SHALL, on reset mid-RECV or mid-DRAIN, abandon the frame with no further output; reset takes priority over every other event in the same cycle.

Verification
REQ-032 SHALL cover: len=0, msb=1, bits 1,0,1,1,0,0,1,0 then si_valid=0 -> one byte 0xB2 at out_addr 0x00, frame_done pulse.
REQ-033 SHALL cover: len=1, msb=0, 16 bits of 0x1234 sent LSB-first with out_ready=1 -> bytes 0x34 then 0x12 at addrs 0,1.
REQ-034 SHALL cover: len=3 with 24 bits sent -> frame_err pulse, no out_valid, out_addr unchanged; next good 8-bit frame -> accepted.
REQ-035 SHALL cover: len=2 with out_ready held 0 for 5 cycles in DRAIN -> out_valid/out_data/out_addr stable, then 3 bytes delivered in order.
REQ-036 SHALL cover: 256 good 8-bit frames -> out_addr wraps 0xFF to 0x00 on frame 257; si_valid=1 during DRAIN -> overrun pulse, frame not started.
REQ-037 SHALL cover: reset asserted during RECV after 12 bits -> all outputs 0 next cycle; a following 8-bit frame is received correctly at addr 0.
